axis_rr_arbiter: RTL and testbench
==================================

AXIS_RR_ARBITER -- requirements
Module: axis_rr_arbiter

Interface
Parameters:
REQ-001 The block SHALL have parameter N_SRC, default 4, giving the number of requesting AXI4-Stream routed sources (range 2..16).
REQ-002 The block SHALL have parameter DATA_BITS, default AXI_DATA_BITS (512), giving the tdata width; tkeep is DATA_BITS/8 wide.
REQ-003 The block SHALL have parameter ID_BITS, default PID_BITS (6), giving the tid width.

Ports:
REQ-004 aclk  input  1  single clock; all logic on its rising edge.
REQ-005 aresetn  input  1  reset, synchronous, active-low.
REQ-006 s_tvalid  input  N_SRC  per-source valid.
REQ-007 s_tready  output  N_SRC  per-source ready.
REQ-008 s_tdata  input  N_SRC*DATA_BITS  per-source data; source i occupies slice i.
REQ-009 s_tkeep  input  N_SRC*DATA_BITS/8  per-source byte keep.
REQ-010 s_tlast  input  N_SRC  per-source end of packet.
REQ-011 s_tid  input  N_SRC*ID_BITS  per-source tid.
REQ-012 m_tvalid, m_tdata, m_tkeep, m_tlast, m_tid  output  1/DATA_BITS/DATA_BITS/8/1/ID_BITS  shared output stream.
REQ-013 m_tready  input  1  downstream ready.
REQ-014 m_tsrc  output  clog2(N_SRC)  index of the currently granted source.
REQ-015 busy  output  1  high while a grant is held.

Function
REQ-016 The arbiter SHALL be an FSM with two states: IDLE and GRANT.
REQ-017 IDLE behaviour:
- all s_tready = 0 and m_tvalid = 0;
- if any s_tvalid = 1, it SHALL register grant = the first requesting index found by scanning last_grant+1, last_grant+2, ... modulo N_SRC, then enter GRANT on the next edge.
REQ-018 GRANT behaviour:
- m_tvalid/m_tdata/m_tkeep/m_tlast/m_tid SHALL combinationally equal source[grant];
- s_tready[grant] = m_tready;
- all other s_tready = 0.
REQ-019 Grant SHALL be packet-granular: grant and m_tsrc SHALL NOT change in GRANT until a beat with m_tvalid & m_tready & m_tlast completes.
REQ-020 On that tlast handshake:
- last_grant <= grant;
- the FSM returns to IDLE on the next edge.
REQ-021 Arbitration latency SHALL be exactly one cycle: a request seen in IDLE at cycle t is presented on m_* at cycle t+1. Consequently there is one idle cycle between consecutive packets.
REQ-022 In GRANT, a deasserted s_tvalid[grant] SHALL hold the grant (mid-packet bubbles allowed) with m_tvalid = 0.
REQ-023 Sources not granted SHALL see s_tready = 0 regardless of their own tvalid or tlast.
REQ-024 A single-beat packet (tlast on the first beat) SHALL complete in GRANT in one cycle when m_tready = 1.
REQ-025 m_tsrc SHALL equal the registered grant in all states; busy SHALL be 1 exactly in GRANT.
REQ-026 Round-robin fairness: with all N_SRC sources continuously requesting, each source SHALL receive exactly one packet grant per N_SRC packets.
REQ-027 Index arithmetic SHALL wrap modulo N_SRC, including non-power-of-two N_SRC; for example, N_SRC=3 with last_grant=2 scans 0 first.

Reset
REQ-028 While aresetn = 0 at a rising edge, the block SHALL enter IDLE and set last_grant = N_SRC-1 (source 0 has highest first priority), grant = 0, m_tsrc = 0, busy = 0.
REQ-029 During reset, all s_tready = 0 and m_tvalid = 0, including a reset asserted mid-packet. The partial packet is abandoned, and no beat is accepted in the reset cycle.
REQ-030 After aresetn returns to 1, the first grant SHALL occur no earlier than the cycle after the first IDLE cycle.

Verification
REQ-031 After reset, sources 0 and 2 both request 3-beat packets, m_tready = 1 -> source 0 is output on cycles 1-3 (m_tsrc = 0), IDLE on cycle 4, source 2 on cycles 5-7.
REQ-032 All 4 sources continuously request single-beat packets -> m_tsrc sequence 0,1,2,3,0,1 with one idle cycle between grants.
REQ-033 Source 1 is granted, m_tready toggles 1,0,1,0 and s_tvalid[1] drops for 2 cycles mid-packet -> no beat is lost or duplicated, m_tsrc stays 1, and source 3 (requesting) sees s_tready[3] = 0 throughout.
REQ-034 aresetn is pulsed low for 1 cycle during beat 2 of a 5-beat packet from source 2 -> s_tready = 0 and m_tvalid = 0 in the reset cycle; the next grant goes to source 0 if it is requesting, and otherwise follows the scan from 0.
REQ-035 N_SRC = 3, last_grant = 2, requests pending on 1 and 2 -> grant = 1; after that packet, grant = 2.
REQ-036 A single-beat packet with tlast = 1, tid = 6'h2A and tkeep all-ones from source 3 -> m_tid = 6'h2A, m_tlast = 1, m_tkeep all-ones in one cycle, followed by a return to IDLE.

Source files
------------

// File: rtl/axis_rr_arbiter.sv
// Packet-granular round-robin arbiter merging N_SRC AXI4-Stream sources onto one output.
// One arbitration cycle in IDLE; the grant is then held until the granted source's tlast beat.
module axis_rr_arbiter #(
    parameter int unsigned N_SRC     = 4,
    parameter int unsigned DATA_BITS = 512,
    parameter int unsigned ID_BITS   = 6,
    localparam int unsigned KEEP_BITS = DATA_BITS / 8,
    localparam int unsigned SRC_BITS  = $clog2(N_SRC)
) (
    input  logic                       aclk,
    input  logic                       aresetn,

    input  logic [N_SRC-1:0]           s_tvalid,
    output logic [N_SRC-1:0]           s_tready,
    input  logic [N_SRC*DATA_BITS-1:0] s_tdata,
    input  logic [N_SRC*KEEP_BITS-1:0] s_tkeep,
    input  logic [N_SRC-1:0]           s_tlast,
    input  logic [N_SRC*ID_BITS-1:0]   s_tid,

    output logic                       m_tvalid,
    input  logic                       m_tready,
    output logic [DATA_BITS-1:0]       m_tdata,
    output logic [KEEP_BITS-1:0]       m_tkeep,
    output logic                       m_tlast,
    output logic [ID_BITS-1:0]         m_tid,
    output logic [SRC_BITS-1:0]        m_tsrc,
    output logic                       busy
);

    localparam logic [0:0] StIdle  = 1'b0;
    localparam logic [0:0] StGrant = 1'b1;

    logic [0:0]          state_q, state_d;
    logic [SRC_BITS-1:0] grant_q, grant_d;
    logic [SRC_BITS-1:0] last_grant_q, last_grant_d;

    logic [SRC_BITS-1:0] next_grant;
    logic                any_req;
    logic [N_SRC-1:0]    grant_oh;
    logic                in_grant;
    logic                pkt_done;

    logic                 sel_tvalid;
    logic [DATA_BITS-1:0] sel_tdata;
    logic [KEEP_BITS-1:0] sel_tkeep;
    logic                 sel_tlast;
    logic [ID_BITS-1:0]   sel_tid;

    // Scan last_grant+1, last_grant+2, ... modulo N_SRC; the first requester found wins.
    always_comb begin
        logic [SRC_BITS-1:0] idx;
        idx        = '0;
        next_grant = '0;
        any_req    = 1'b0;
        for (int unsigned k = 1; k <= N_SRC; k++) begin
            idx = SRC_BITS'((32'(last_grant_q) + k) % N_SRC);
            if (!any_req && s_tvalid[idx]) begin
                any_req    = 1'b1;
                next_grant = idx;
            end
        end
    end

    always_comb begin
        grant_oh = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            grant_oh[i] = (grant_q == SRC_BITS'(i));
        end
    end

    always_comb begin
        sel_tvalid = 1'b0;
        sel_tdata  = '0;
        sel_tkeep  = '0;
        sel_tlast  = 1'b0;
        sel_tid    = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (grant_oh[i]) begin
                sel_tvalid = s_tvalid[i];
                sel_tdata  = s_tdata[i*DATA_BITS +: DATA_BITS];
                sel_tkeep  = s_tkeep[i*KEEP_BITS +: KEEP_BITS];
                sel_tlast  = s_tlast[i];
                sel_tid    = s_tid[i*ID_BITS +: ID_BITS];
            end
        end
    end

    // Reset gates the handshake outputs so nothing is accepted in a reset cycle.
    assign in_grant = aresetn && (state_q == StGrant);

    always_comb begin
        m_tvalid = in_grant && sel_tvalid;
        m_tdata  = sel_tdata;
        m_tkeep  = sel_tkeep;
        m_tlast  = sel_tlast;
        m_tid    = sel_tid;
        s_tready = in_grant ? (grant_oh & {N_SRC{m_tready}}) : '0;
    end

    assign pkt_done = m_tvalid && m_tready && m_tlast;
    assign m_tsrc   = grant_q;
    assign busy     = (state_q == StGrant);

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        case (state_q)
            StIdle: begin
                if (any_req) begin
                    grant_d = next_grant;
                    state_d = StGrant;
                end
            end
            StGrant: begin
                if (pkt_done) begin
                    last_grant_d = grant_q;
                    state_d      = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q      <= StIdle;
            grant_q      <= '0;
            last_grant_q <= SRC_BITS'(N_SRC - 1);
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Bench for axis_rr_arbiter: a queue-free rotation model checked every cycle, plus
// directed scenarios with hand-computed traces (4-source and 3-source instances).
module tb_axis_rr_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned NB = 3;
    localparam int unsigned DW = 32;
    localparam int unsigned KW = DW / 8;
    localparam int unsigned IW = 6;

    logic aclk = 1'b0;
    always #5 aclk = ~aclk;

    logic aresetn = 1'b0;

    logic [N-1:0]    s_tvalid, s_tready, s_tlast;
    logic [N*DW-1:0] s_tdata;
    logic [N*KW-1:0] s_tkeep;
    logic [N*IW-1:0] s_tid;
    logic            m_tvalid, m_tready, m_tlast, busy;
    logic [DW-1:0]   m_tdata;
    logic [KW-1:0]   m_tkeep;
    logic [IW-1:0]   m_tid;
    logic [1:0]      m_tsrc;

    logic [NB-1:0]    b_tvalid, b_tready, b_tlast;
    logic [NB*DW-1:0] b_tdata;
    logic [NB*KW-1:0] b_tkeep;
    logic [NB*IW-1:0] b_tid;
    logic             bm_tvalid, bm_tready, bm_tlast, b_busy;
    logic [DW-1:0]    bm_tdata;
    logic [KW-1:0]    bm_tkeep;
    logic [IW-1:0]    bm_tid;
    logic [1:0]       b_tsrc;

    axis_rr_arbiter #(.N_SRC(N), .DATA_BITS(DW), .ID_BITS(IW)) dut_a (
        .aclk(aclk), .aresetn(aresetn),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tkeep(s_tkeep),
        .s_tlast(s_tlast), .s_tid(s_tid),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tkeep(m_tkeep),
        .m_tlast(m_tlast), .m_tid(m_tid), .m_tsrc(m_tsrc), .busy(busy)
    );

    axis_rr_arbiter #(.N_SRC(NB), .DATA_BITS(DW), .ID_BITS(IW)) dut_b (
        .aclk(aclk), .aresetn(aresetn),
        .s_tvalid(b_tvalid), .s_tready(b_tready), .s_tdata(b_tdata), .s_tkeep(b_tkeep),
        .s_tlast(b_tlast), .s_tid(b_tid),
        .m_tvalid(bm_tvalid), .m_tready(bm_tready), .m_tdata(bm_tdata), .m_tkeep(bm_tkeep),
        .m_tlast(bm_tlast), .m_tid(bm_tid), .m_tsrc(b_tsrc), .busy(b_busy)
    );

    int checks = 0;
    int failures = 0;

    function automatic void chk(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endfunction

    // Source behaviour: npk packets of len beats; tdata = {src, pkt, beat}.
    int          npk [N];
    int          len [N];
    int          beat[N];
    int          pkt [N];
    bit          gap [N];
    logic [IW-1:0] tidc[N];
    logic [N-1:0]  hs_cap = '0;

    typedef struct {
        logic          tv;
        logic [N-1:0]  tr;
        logic [1:0]    src;
        logic          bsy;
        logic [IW-1:0] tid;
        logic          tl;
        logic [KW-1:0] kp;
        logic          b_tv;
        logic [1:0]    b_src;
        logic          b_bsy;
        logic [DW-1:0] b_dat;
    } trace_t;

    trace_t        trace[$];
    logic [DW-1:0] acc[$];

    // Model: owner of the output (-1 when idle), last served index, index shown on m_tsrc.
    int own   = -1;
    int ptr   = N - 1;
    int shown = 0;
    bit live  = 1'b0;

    initial begin
        trace_t e;
        logic   exp_tv;
        forever begin
            @(negedge aclk);
            if (live) begin
                exp_tv = aresetn && (own >= 0) && s_tvalid[own];
                chk($sformatf("model m_tvalid @%0t", $time), 64'(m_tvalid), 64'(exp_tv));
                chk($sformatf("model s_tready @%0t", $time), 64'(s_tready),
                    (aresetn && own >= 0 && m_tready) ? 64'(1 << own) : 64'(0));
                chk($sformatf("model m_tsrc @%0t", $time), 64'(m_tsrc), 64'(shown));
                chk($sformatf("model busy @%0t", $time), 64'(busy), 64'(own >= 0));
                if (exp_tv) begin
                    chk($sformatf("model m_tdata @%0t", $time), 64'(m_tdata),
                        64'(s_tdata[own*DW +: DW]));
                    chk($sformatf("model m_tkeep @%0t", $time), 64'(m_tkeep),
                        64'(s_tkeep[own*KW +: KW]));
                    chk($sformatf("model m_tlast @%0t", $time), 64'(m_tlast),
                        64'(s_tlast[own]));
                    chk($sformatf("model m_tid @%0t", $time), 64'(m_tid),
                        64'(s_tid[own*IW +: IW]));
                end
            end
            e.tv = m_tvalid; e.tr = s_tready; e.src = m_tsrc; e.bsy = busy;
            e.tid = m_tid; e.tl = m_tlast; e.kp = m_tkeep;
            e.b_tv = bm_tvalid; e.b_src = b_tsrc; e.b_bsy = b_busy; e.b_dat = bm_tdata;
            trace.push_back(e);
            if (m_tvalid && m_tready && aresetn) acc.push_back(m_tdata);
            hs_cap = s_tvalid & s_tready & {N{aresetn}};
            // Advance the model to what the coming edge must produce.
            if (!aresetn) begin
                own = -1; ptr = N - 1; shown = 0; live = 1'b1;
            end else if (own < 0) begin
                for (int k = 1; k <= N; k++) begin
                    if (own < 0 && s_tvalid[(ptr + k) % N]) begin
                        own   = (ptr + k) % N;
                        shown = own;
                    end
                end
            end else if (s_tvalid[own] && m_tready && s_tlast[own]) begin
                ptr = own;
                own = -1;
            end
        end
    end

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            s_tvalid[i]          = (npk[i] > 0) && !gap[i];
            s_tdata[i*DW +: DW]  = {8'(i), 8'(pkt[i]), 16'(beat[i])};
            s_tlast[i]           = (beat[i] == len[i] - 1);
            s_tid[i*IW +: IW]    = tidc[i];
            s_tkeep[i*KW +: KW]  = '1;
        end
    endtask

    task automatic cycle();
        @(posedge aclk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (hs_cap[i]) begin
                beat[i]++;
                if (beat[i] == len[i]) begin
                    beat[i] = 0;
                    pkt[i]++;
                    npk[i]--;
                end
            end
        end
        drive();
    endtask

    task automatic clear_src();
        for (int i = 0; i < N; i++) begin
            npk[i] = 0; len[i] = 1; beat[i] = 0; pkt[i] = 0; gap[i] = 1'b0;
            tidc[i] = IW'(i);
        end
        m_tready  = 1'b1;
        b_tvalid  = '0;
        bm_tready = 1'b1;
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        drive();
        cycle();
        cycle();
        clear_src();
        drive();
    endtask

    task automatic release_rst();
        aresetn = 1'b1;
        trace.delete();
        acc.delete();
    endtask

    int          t1_tv [9]  = '{0, 1, 1, 1, 0, 1, 1, 1, 0};
    int          t1_src[9]  = '{0, 0, 0, 0, 0, 2, 2, 2, 2};
    logic [31:0] t1_acc[6]  = '{32'h0000_0000, 32'h0000_0001, 32'h0000_0002,
                                32'h0200_0000, 32'h0200_0001, 32'h0200_0002};
    int          t2_src[12] = '{0, 0, 0, 1, 1, 2, 2, 3, 3, 0, 0, 1};
    bit          t3_rdy[12] = '{1, 1, 0, 1, 0, 1, 1, 0, 1, 1, 1, 1};
    bit          t3_gap[12] = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0};
    int          t3_tv [12] = '{0, 1, 1, 1, 0, 0, 1, 1, 1, 0, 1, 0};
    int          t3_tr [12] = '{0, 2, 0, 2, 0, 2, 2, 0, 2, 0, 8, 0};
    int          t3_src[12] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 3, 3};
    logic [31:0] t3_acc[5]  = '{32'h0100_0000, 32'h0100_0001, 32'h0100_0002,
                                32'h0100_0003, 32'h0300_0000};
    int          t4_tv [10] = '{0, 1, 1, 0, 0, 1, 1, 0, 1, 1};
    int          t4_src[10] = '{0, 2, 2, 2, 0, 0, 0, 0, 2, 2};
    logic [31:0] t4_acc[6]  = '{32'h0200_0000, 32'h0200_0001, 32'h0000_0000,
                                32'h0000_0001, 32'h0200_0000, 32'h0200_0001};
    int          t6_tv [6]  = '{0, 1, 0, 1, 0, 1};
    int          t6_src[6]  = '{0, 1, 1, 2, 2, 1};

    initial begin
        b_tdata = {32'h2222_2222, 32'h1111_1111, 32'h0000_0000};
        b_tkeep = '1;
        b_tlast = '1;
        b_tid   = '0;
        clear_src();
        drive();
        do_reset();

        // Two 3-beat packets from sources 0 and 2; also pins the post-reset state.
        npk[0] = 1; len[0] = 3; npk[2] = 1; len[2] = 3;
        drive();
        release_rst();
        repeat (9) cycle();
        chk("t1 reset s_tready", 64'(trace[0].tr), 64'(0));
        chk("t1 reset busy", 64'(trace[0].bsy), 64'(0));
        for (int k = 0; k < 9; k++) begin
            chk($sformatf("t1 m_tvalid c%0d", k), 64'(trace[k].tv), 64'(t1_tv[k]));
            chk($sformatf("t1 m_tsrc c%0d", k), 64'(trace[k].src), 64'(t1_src[k]));
        end
        chk("t1 beats accepted", 64'(acc.size()), 64'(6));
        for (int k = 0; k < 6; k++) chk($sformatf("t1 beat %0d", k), 64'(acc[k]), 64'(t1_acc[k]));

        // All four sources streaming single-beat packets.
        do_reset();
        for (int i = 0; i < N; i++) begin npk[i] = 100; len[i] = 1; end
        drive();
        release_rst();
        repeat (12) cycle();
        for (int k = 0; k < 12; k++) begin
            chk($sformatf("t2 m_tvalid c%0d", k), 64'(trace[k].tv), 64'(k % 2));
            chk($sformatf("t2 m_tsrc c%0d", k), 64'(trace[k].src), 64'(t2_src[k]));
        end

        // Backpressure and a mid-packet bubble on source 1 while source 3 waits.
        do_reset();
        npk[1] = 1; len[1] = 4; npk[3] = 1; len[3] = 1;
        drive();
        release_rst();
        for (int k = 0; k < 12; k++) begin
            m_tready = t3_rdy[k];
            gap[1]   = t3_gap[k];
            drive();
            cycle();
        end
        for (int k = 0; k < 12; k++) begin
            chk($sformatf("t3 m_tvalid c%0d", k), 64'(trace[k].tv), 64'(t3_tv[k]));
            chk($sformatf("t3 s_tready c%0d", k), 64'(trace[k].tr), 64'(t3_tr[k]));
            chk($sformatf("t3 m_tsrc c%0d", k), 64'(trace[k].src), 64'(t3_src[k]));
        end
        chk("t3 beats accepted", 64'(acc.size()), 64'(5));
        for (int k = 0; k < 5; k++) chk($sformatf("t3 beat %0d", k), 64'(acc[k]), 64'(t3_acc[k]));

        // One-cycle reset pulse while source 2 presents beat 2 of a 5-beat packet.
        do_reset();
        npk[2] = 1; len[2] = 5;
        drive();
        release_rst();
        repeat (3) cycle();
        aresetn = 1'b0;
        npk[0] = 1; len[0] = 2;
        drive();
        cycle();
        for (int i = 0; i < N; i++) beat[i] = 0;
        aresetn = 1'b1;
        drive();
        repeat (6) cycle();
        chk("t4 reset-cycle s_tready", 64'(trace[3].tr), 64'(0));
        chk("t4 post-reset busy", 64'(trace[4].bsy), 64'(0));
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("t4 m_tvalid c%0d", k), 64'(trace[k].tv), 64'(t4_tv[k]));
            chk($sformatf("t4 m_tsrc c%0d", k), 64'(trace[k].src), 64'(t4_src[k]));
        end
        chk("t4 beats accepted", 64'(acc.size()), 64'(6));
        for (int k = 0; k < 6; k++) chk($sformatf("t4 beat %0d", k), 64'(acc[k]), 64'(t4_acc[k]));

        // Single-beat packet from source 3 with tid 0x2A.
        do_reset();
        npk[3] = 1; len[3] = 1; tidc[3] = 6'h2A;
        drive();
        release_rst();
        repeat (4) cycle();
        chk("t5 m_tvalid", 64'(trace[1].tv), 64'(1));
        chk("t5 m_tsrc", 64'(trace[1].src), 64'(3));
        chk("t5 m_tid", 64'(trace[1].tid), 64'h2A);
        chk("t5 m_tlast", 64'(trace[1].tl), 64'(1));
        chk("t5 m_tkeep", 64'(trace[1].kp), 64'hF);
        chk("t5 s_tready", 64'(trace[1].tr), 64'h8);
        chk("t5 idle m_tvalid", 64'(trace[2].tv), 64'(0));
        chk("t5 idle busy", 64'(trace[2].bsy), 64'(0));

        // Three-source instance: requests on 1 and 2 after reset.
        do_reset();
        b_tvalid = 3'b110;
        release_rst();
        repeat (6) cycle();
        chk("t6 first idle busy", 64'(trace[0].b_bsy), 64'(0));
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("t6 m_tvalid c%0d", k), 64'(trace[k].b_tv), 64'(t6_tv[k]));
            chk($sformatf("t6 m_tsrc c%0d", k), 64'(trace[k].b_src), 64'(t6_src[k]));
        end
        chk("t6 data src1", 64'(trace[1].b_dat), 64'h1111_1111);
        chk("t6 data src2", 64'(trace[3].b_dat), 64'h2222_2222);
        b_tvalid = '0;
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
